// File: rtl/stage_modulation_param_pkg.sv
// -----------------------------------------------------------------------------
// stage_modulation_param_pkg
//   Shared synth definitions for the modulation-phase pipeline: voice and
//   operator counts, the {voice, op} identifier and the per-operator algorithm
//   word (one "modulate with operator k" bit per operator).
//   No ports (package).
// -----------------------------------------------------------------------------
package stage_modulation_param_pkg;

  localparam int NUM_VOICES = 32;
  localparam int NUM_OPS    = 6;
  localparam int VOICE_W    = $clog2(NUM_VOICES);
  localparam int OP_W       = $clog2(NUM_OPS);

  typedef struct packed {
    logic [VOICE_W-1:0] voice;
    logic [OP_W-1:0]    op;
  } VoiceOperatorID_t;

  typedef struct packed {
    logic [NUM_OPS-1:0] ModulateWithOP;
  } AlgorithmWord_t;

  // Accumulator wide enough that NUM_OPS full-scale samples can never overflow.
  function automatic int acc_width(input int sample_w, input int num_ops);
    return sample_w + $clog2(num_ops);
  endfunction

endpackage

// File: rtl/stage_modulation_param_modulation_tap.sv
// -----------------------------------------------------------------------------
// modulation_tap
//   One accumulate stage of the modulation pipeline. Owns a private replica of
//   the operator-output memory (all replicas receive the same writes), reads
//   operator TAP_OP of the incoming voice and adds it to the running sum when
//   the item's algorithm word selects that operator. One register stage.
//
// Ports
//   i_clock, i_reset_n        clock, async active-low reset (valid bit only)
//   i_valid/i_id/i_alg/i_acc  item entering this stage
//   o_valid/o_id/o_alg/o_acc  item leaving this stage (registered)
//   i_op_we/i_op_waddr/i_op_wdata  operator-memory write port (shared)
// -----------------------------------------------------------------------------
module modulation_tap
  import stage_modulation_param_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int SAMPLE_W  = 16,
  parameter int ACC_W     = 19,
  parameter int TAP_OP    = 0
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_valid,
  input  VoiceOperatorID_t           i_id,
  input  AlgorithmWord_t             i_alg,
  input  logic signed [ACC_W-1:0]    i_acc,
  input  logic                       i_op_we,
  input  VoiceOperatorID_t           i_op_waddr,
  input  logic signed [SAMPLE_W-1:0] i_op_wdata,
  output logic                       o_valid,
  output VoiceOperatorID_t           o_id,
  output AlgorithmWord_t             o_alg,
  output logic signed [ACC_W-1:0]    o_acc
);

  logic signed [SAMPLE_W-1:0] op_mem_q [MEM_DEPTH];

  VoiceOperatorID_t           rd_addr;
  logic signed [SAMPLE_W-1:0] rd_data;
  logic signed [ACC_W-1:0]    addend;

  logic                    valid_d, valid_q;
  VoiceOperatorID_t        id_d, id_q;
  AlgorithmWord_t          alg_d, alg_q;
  logic signed [ACC_W-1:0] acc_d, acc_q;

  // NOTE: storage arrays carry no reset; software loads them before use, and a
  // reset term would stop the array from mapping onto RAM.
  always_ff @(posedge i_clock) begin
    if (i_op_we) begin
      op_mem_q[i_op_waddr] <= i_op_wdata;
    end
  end

  // The read is combinational on the incoming ID and consumed at the same edge
  // as any write, so a same-address write in that cycle returns the old value.
  // NOTE: every signal assigned here gets a value on every path (defaults
  // first) so no latch is inferred.
  always_comb begin
    rd_addr    = i_id;
    rd_addr.op = OP_W'(TAP_OP);
    rd_data    = op_mem_q[rd_addr];
    addend     = '0;
    if (i_alg.ModulateWithOP[TAP_OP]) begin
      addend = {{(ACC_W-SAMPLE_W){rd_data[SAMPLE_W-1]}}, rd_data};
    end
    valid_d = i_valid;
    id_d    = i_id;
    alg_d   = i_alg;
    acc_d   = i_acc + addend;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge i_clock) begin
    id_q  <= id_d;
    alg_q <= alg_d;
    acc_q <= acc_d;
  end

  assign o_valid = valid_q;
  assign o_id    = id_q;
  assign o_alg   = alg_q;
  assign o_acc   = acc_q;

endmodule

// File: rtl/stage_modulation_param.sv
// -----------------------------------------------------------------------------
// stage_modulation_param
//   Fully pipelined modulation-phase stage. Each accepted {voice, op} ID picks
//   up its algorithm word at entry, then walks NUM_OPS accumulate taps that add
//   the stored outputs of the selected operators of the same voice. The sum is
//   arithmetically shifted right by OUT_SHIFT and narrowed to SAMPLE_W.
//   Latency is NUM_OPS+2 cycles; bubbles pass through as o_Valid=0 while the
//   data outputs hold their last value.
//
// Ports
//   i_Clock, i_Reset_n          clock, async active-low reset
//   i_Valid, i_VoiceOperator    ID to evaluate this cycle
//   o_Valid, o_VoiceOperator    result valid and its ID
//   o_ModulationPhase           scaled modulation sum (signed SAMPLE_W)
//   o_AlgorithmWord             algorithm word the result was computed with
//   i_AlgorithmWrite*           algorithm-table write port
//   i_OperatorWrite*            operator-output memory write port
//
// Build option
//   STAGE_MODULATION_SATURATE_EN  defined: clamp the shifted sum to SAMPLE_W;
//                                 undefined: keep the low SAMPLE_W bits (wrap).
//
// NUM_VOICES and NUM_OPS must match the package, which sizes the port types.
// -----------------------------------------------------------------------------
module stage_modulation_param
  import stage_modulation_param_pkg::*;
#(
  parameter int NUM_VOICES = stage_modulation_param_pkg::NUM_VOICES,
  parameter int NUM_OPS    = stage_modulation_param_pkg::NUM_OPS,
  parameter int SAMPLE_W   = 16,
  parameter int OUT_SHIFT  = 3
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_n,
  input  logic                       i_Valid,
  input  VoiceOperatorID_t           i_VoiceOperator,
  output logic                       o_Valid,
  output VoiceOperatorID_t           o_VoiceOperator,
  output logic signed [SAMPLE_W-1:0] o_ModulationPhase,
  output AlgorithmWord_t             o_AlgorithmWord,
  input  logic                       i_AlgorithmWriteEnable,
  input  VoiceOperatorID_t           i_AlgorithmWriteAddr,
  input  AlgorithmWord_t             i_AlgorithmWriteData,
  input  logic                       i_OperatorWriteEnable,
  input  VoiceOperatorID_t           i_OperatorWriteAddr,
  input  logic signed [SAMPLE_W-1:0] i_OperatorWriteData
);

  localparam int ACC_W     = acc_width(SAMPLE_W, NUM_OPS);
  localparam int MEM_DEPTH = NUM_VOICES * (2 ** OP_W);

  // ---------------------------------------------------------------------------
  // Algorithm table and stage 0 (ID, algorithm word, valid)
  // ---------------------------------------------------------------------------
  AlgorithmWord_t alg_mem_q [MEM_DEPTH];

  always_ff @(posedge i_Clock) begin
    if (i_AlgorithmWriteEnable) begin
      alg_mem_q[i_AlgorithmWriteAddr] <= i_AlgorithmWriteData;
    end
  end

  logic             s0_valid_d, s0_valid_q;
  VoiceOperatorID_t s0_id_d, s0_id_q;
  AlgorithmWord_t   s0_alg_d, s0_alg_q;

  // The word is latched here and carried with the ID, so later table writes
  // never reach items already in flight.
  always_comb begin
    s0_valid_d = i_Valid;
    s0_id_d    = i_VoiceOperator;
    s0_alg_d   = alg_mem_q[i_VoiceOperator];
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      s0_valid_q <= 1'b0;
    end else begin
      s0_valid_q <= s0_valid_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    s0_id_q  <= s0_id_d;
    s0_alg_q <= s0_alg_d;
  end

  // ---------------------------------------------------------------------------
  // Accumulate taps: element k of each chain feeds tap k (operator k).
  // ---------------------------------------------------------------------------
  logic                    chain_valid [NUM_OPS+1];
  VoiceOperatorID_t        chain_id    [NUM_OPS+1];
  AlgorithmWord_t          chain_alg   [NUM_OPS+1];
  logic signed [ACC_W-1:0] chain_acc   [NUM_OPS+1];

  assign chain_valid[0] = s0_valid_q;
  assign chain_id[0]    = s0_id_q;
  assign chain_alg[0]   = s0_alg_q;
  assign chain_acc[0]   = '0;

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_tap
    modulation_tap #(
      .MEM_DEPTH (MEM_DEPTH),
      .SAMPLE_W  (SAMPLE_W),
      .ACC_W     (ACC_W),
      .TAP_OP    (k)
    ) u_tap (
      .i_clock    (i_Clock),
      .i_reset_n  (i_Reset_n),
      .i_valid    (chain_valid[k]),
      .i_id       (chain_id[k]),
      .i_alg      (chain_alg[k]),
      .i_acc      (chain_acc[k]),
      .i_op_we    (i_OperatorWriteEnable),
      .i_op_waddr (i_OperatorWriteAddr),
      .i_op_wdata (i_OperatorWriteData),
      .o_valid    (chain_valid[k+1]),
      .o_id       (chain_id[k+1]),
      .o_alg      (chain_alg[k+1]),
      .o_acc      (chain_acc[k+1])
    );
  end

  // ---------------------------------------------------------------------------
  // Scale stage: arithmetic shift, then clamp or wrap to SAMPLE_W.
  // ---------------------------------------------------------------------------
`ifdef STAGE_MODULATION_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SAMPLE_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (SAMPLE_W-1)));
`endif

  logic signed [ACC_W-1:0]    shifted_acc;
  logic                       fin_valid_d, fin_valid_q;
  VoiceOperatorID_t           fin_id_d, fin_id_q;
  AlgorithmWord_t             fin_alg_d, fin_alg_q;
  logic signed [SAMPLE_W-1:0] fin_phase_d, fin_phase_q;

  always_comb begin
    shifted_acc = chain_acc[NUM_OPS] >>> OUT_SHIFT;
`ifdef STAGE_MODULATION_SATURATE_EN
    if (shifted_acc > SAT_MAX) begin
      fin_phase_d = SAMPLE_W'(SAT_MAX);
    end else if (shifted_acc < SAT_MIN) begin
      fin_phase_d = SAMPLE_W'(SAT_MIN);
    end else begin
      fin_phase_d = SAMPLE_W'(shifted_acc);
    end
`else
    fin_phase_d = SAMPLE_W'(shifted_acc);
`endif
    fin_valid_d = chain_valid[NUM_OPS];
    fin_id_d    = chain_id[NUM_OPS];
    fin_alg_d   = chain_alg[NUM_OPS];
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      fin_valid_q <= 1'b0;
    end else begin
      fin_valid_q <= fin_valid_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    fin_id_q    <= fin_id_d;
    fin_alg_q   <= fin_alg_d;
    fin_phase_q <= fin_phase_d;
  end

  // ---------------------------------------------------------------------------
  // Output stage: data registers load only on a valid result and hold across
  // bubbles; everything visible clears on reset.
  // ---------------------------------------------------------------------------
  logic                       out_valid_d, out_valid_q;
  VoiceOperatorID_t           out_id_d, out_id_q;
  AlgorithmWord_t             out_alg_d, out_alg_q;
  logic signed [SAMPLE_W-1:0] out_phase_d, out_phase_q;

  always_comb begin
    out_valid_d = fin_valid_q;
    out_id_d    = out_id_q;
    out_alg_d   = out_alg_q;
    out_phase_d = out_phase_q;
    if (fin_valid_q) begin
      out_id_d    = fin_id_q;
      out_alg_d   = fin_alg_q;
      out_phase_d = fin_phase_q;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_alg_q   <= '0;
      out_phase_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_alg_q   <= out_alg_d;
      out_phase_q <= out_phase_d;
    end
  end

  assign o_Valid           = out_valid_q;
  assign o_VoiceOperator   = out_id_q;
  assign o_AlgorithmWord   = out_alg_q;
  assign o_ModulationPhase = out_phase_q;

endmodule

// File: tb/tb_stage_modulation_param.sv
// -----------------------------------------------------------------------------
// tb_stage_modulation_param
//   Two instances share all inputs: u_dut (OUT_SHIFT=3) and u_dut_s0
//   (OUT_SHIFT=0). A behavioural model (per-voice operator values, algorithm
//   table, sum-of-selected-operators arithmetic) predicts every output cycle;
//   expectations queue up and emerge eight cycles after entry.
// -----------------------------------------------------------------------------
module tb_stage_modulation_param;
  import stage_modulation_param_pkg::*;

  localparam int LAT = NUM_OPS + 2;

  logic                 i_Clock;
  logic                 i_Reset_n;
  logic                 i_Valid;
  VoiceOperatorID_t     i_VoiceOperator;
  logic                 i_AlgorithmWriteEnable;
  VoiceOperatorID_t     i_AlgorithmWriteAddr;
  AlgorithmWord_t       i_AlgorithmWriteData;
  logic                 i_OperatorWriteEnable;
  VoiceOperatorID_t     i_OperatorWriteAddr;
  logic signed [15:0]   i_OperatorWriteData;

  logic                 o_Valid, s0_Valid;
  VoiceOperatorID_t     o_VoiceOperator, s0_VoiceOperator;
  logic signed [15:0]   o_ModulationPhase, s0_ModulationPhase;
  AlgorithmWord_t       o_AlgorithmWord, s0_AlgorithmWord;

  stage_modulation_param #(.SAMPLE_W(16), .OUT_SHIFT(3)) u_dut (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n),
    .i_Valid(i_Valid), .i_VoiceOperator(i_VoiceOperator),
    .o_Valid(o_Valid), .o_VoiceOperator(o_VoiceOperator),
    .o_ModulationPhase(o_ModulationPhase), .o_AlgorithmWord(o_AlgorithmWord),
    .i_AlgorithmWriteEnable(i_AlgorithmWriteEnable),
    .i_AlgorithmWriteAddr(i_AlgorithmWriteAddr),
    .i_AlgorithmWriteData(i_AlgorithmWriteData),
    .i_OperatorWriteEnable(i_OperatorWriteEnable),
    .i_OperatorWriteAddr(i_OperatorWriteAddr),
    .i_OperatorWriteData(i_OperatorWriteData)
  );

  stage_modulation_param #(.SAMPLE_W(16), .OUT_SHIFT(0)) u_dut_s0 (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n),
    .i_Valid(i_Valid), .i_VoiceOperator(i_VoiceOperator),
    .o_Valid(s0_Valid), .o_VoiceOperator(s0_VoiceOperator),
    .o_ModulationPhase(s0_ModulationPhase), .o_AlgorithmWord(s0_AlgorithmWord),
    .i_AlgorithmWriteEnable(i_AlgorithmWriteEnable),
    .i_AlgorithmWriteAddr(i_AlgorithmWriteAddr),
    .i_AlgorithmWriteData(i_AlgorithmWriteData),
    .i_OperatorWriteEnable(i_OperatorWriteEnable),
    .i_OperatorWriteAddr(i_OperatorWriteAddr),
    .i_OperatorWriteData(i_OperatorWriteData)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests;
  int n_fail;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int op_m  [32][6];   // stored operator outputs, per voice and operator
  int alg_m [32][8];   // algorithm mask per {voice, op}

  function automatic int model_phase(input int voice, input int mask, input int shift);
    int sum = 0;
    int sh;
    for (int k = 0; k < 6; k++) begin
      if (mask[k]) sum += op_m[voice][k];
    end
    sh = sum >>> shift;
`ifdef STAGE_MODULATION_SATURATE_EN
    if (sh > 32767) sh = 32767;
    else if (sh < -32768) sh = -32768;
`else
    sh = sh & 32'hFFFF;
    if (sh > 32767) sh -= 65536;
`endif
    return sh;
  endfunction

  typedef struct {
    bit v;
    int voice;
    int op;
    int alg;
    int p3;
    int p0;
  } exp_t;

  exp_t sb_q[$];
  int held_voice, held_op, held_alg, held_p3, held_p0;

  // Pending writes for the next tick.
  bit aw_en, ow_en;
  int aw_voice, aw_op, aw_mask;
  int ow_voice, ow_op, ow_data;

  task automatic sb_reset();
    exp_t e;
    e.v = 0; e.voice = 0; e.op = 0; e.alg = 0; e.p3 = 0; e.p0 = 0;
    sb_q.delete();
    repeat (LAT) sb_q.push_back(e);
    held_voice = 0; held_op = 0; held_alg = 0; held_p3 = 0; held_p0 = 0;
  endtask

  // One clock: drive at the falling edge, model updates at the rising edge,
  // outputs compared at the next falling edge against the entry LAT edges old.
  task automatic tick(input bit v, input int voice, input int op);
    exp_t e;
    i_Valid                = v;
    i_VoiceOperator.voice  = VOICE_W'(voice);
    i_VoiceOperator.op     = OP_W'(op);
    i_AlgorithmWriteEnable = aw_en;
    i_AlgorithmWriteAddr.voice = VOICE_W'(aw_voice);
    i_AlgorithmWriteAddr.op    = OP_W'(aw_op);
    i_AlgorithmWriteData.ModulateWithOP = NUM_OPS'(aw_mask);
    i_OperatorWriteEnable  = ow_en;
    i_OperatorWriteAddr.voice  = VOICE_W'(ow_voice);
    i_OperatorWriteAddr.op     = OP_W'(ow_op);
    i_OperatorWriteData    = 16'(ow_data);

    e.v     = v;
    e.voice = voice;
    e.op    = op;
    e.alg   = v ? alg_m[voice][op] : 0;
    e.p3    = v ? model_phase(voice, e.alg, 3) : 0;
    e.p0    = v ? model_phase(voice, e.alg, 0) : 0;
    sb_q.push_back(e);

    @(posedge i_Clock);
    if (aw_en) alg_m[aw_voice][aw_op] = aw_mask;
    if (ow_en) op_m[ow_voice][ow_op] = ow_data;
    aw_en = 0;
    ow_en = 0;

    @(negedge i_Clock);
    i_Valid                = 1'b0;
    i_AlgorithmWriteEnable = 1'b0;
    i_OperatorWriteEnable  = 1'b0;

    e = sb_q.pop_front();
    if (e.v) begin
      held_voice = e.voice; held_op = e.op; held_alg = e.alg;
      held_p3 = e.p3; held_p0 = e.p0;
    end
    check("valid",       o_Valid, e.v);
    check("valid_s0",    s0_Valid, e.v);
    check("phase",       o_ModulationPhase, held_p3);
    check("phase_s0",    s0_ModulationPhase, held_p0);
    check("id_voice",    o_VoiceOperator.voice, held_voice);
    check("id_op",       o_VoiceOperator.op, held_op);
    check("alg_word",    o_AlgorithmWord.ModulateWithOP, held_alg);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0);
  endtask

  // Load all six operators of a voice; the algorithm write for {voice,0} rides
  // on the last cycle together with an operator write.
  task automatic program_voice(input int voice, input int data, input int mask);
    for (int k = 0; k < 6; k++) begin
      ow_en = 1; ow_voice = voice; ow_op = k; ow_data = data;
      if (k == 5) begin
        aw_en = 1; aw_voice = voice; aw_op = 0; aw_mask = mask;
      end
      tick(0, 0, 0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int exp_ovf;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    aw_en = 0; ow_en = 0;
    aw_voice = 0; aw_op = 0; aw_mask = 0;
    ow_voice = 0; ow_op = 0; ow_data = 0;
    i_Reset_n = 1'b0;
    i_Valid = 1'b0;
    i_VoiceOperator = '0;
    i_AlgorithmWriteEnable = 1'b0;
    i_AlgorithmWriteAddr = '0;
    i_AlgorithmWriteData = '0;
    i_OperatorWriteEnable = 1'b0;
    i_OperatorWriteAddr = '0;
    i_OperatorWriteData = '0;

    // Reset state
    repeat (3) @(negedge i_Clock);
    check("rst_valid", o_Valid, 0);
    check("rst_valid_s0", s0_Valid, 0);
    check("rst_phase", o_ModulationPhase, 0);
    check("rst_id", {o_VoiceOperator.voice, o_VoiceOperator.op}, 0);
    check("rst_alg", o_AlgorithmWord.ModulateWithOP, 0);
    i_Reset_n = 1'b1;
    sb_reset();

    // Fill both memories with random contents, both ports active together.
    for (int v = 0; v < 32; v++) begin
      for (int o = 0; o < 6; o++) begin
        ow_en = 1; ow_voice = v; ow_op = o;
        ow_data = int'($urandom_range(0, 65535)) - 32768;
        aw_en = 1; aw_voice = v; aw_op = o;
        aw_mask = int'($urandom_range(0, 63));
        tick(0, 0, 0);
      end
    end

    // Single tap: 0x0800 >>> 3 = 0x0100
    program_voice(0, 16'sh0800, 6'b000001);
    tick(1, 0, 0);
    idle(LAT);
    check("single_tap_valid", o_Valid, 1);
    check("single_tap_phase", o_ModulationPhase, 256);
    idle(1);
    check("single_tap_once", o_Valid, 0);

    // Negative full mask: 6 * -32768 >>> 3 = -24576
    program_voice(1, -32768, 6'b111111);
    tick(1, 1, 0);
    idle(LAT);
    check("neg_full_phase", o_ModulationPhase, -24576);

    // Overflow with no shift: 6 * 32767 = 196602
`ifdef STAGE_MODULATION_SATURATE_EN
    exp_ovf = 32767;
`else
    exp_ovf = -6;
`endif
    program_voice(2, 32767, 6'b111111);
    tick(1, 2, 0);
    idle(LAT);
    check("ovf_phase_s0", s0_ModulationPhase, exp_ovf);
    check("ovf_phase_s3", o_ModulationPhase, 24575);
    idle(2);

    // Random stream with gaps and occasional algorithm rewrites, some aimed
    // at the ID entering in the same cycle.
    for (int n = 0; n < 400; n++) begin
      bit v;
      int voice, op;
      v     = ($urandom_range(0, 99) < 65);
      voice = int'($urandom_range(0, 31));
      op    = int'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) begin
        aw_en = 1;
        aw_voice = int'($urandom_range(0, 31));
        aw_op    = int'($urandom_range(0, 5));
        if ($urandom_range(0, 1) == 1) begin
          aw_voice = voice; aw_op = op;
        end
        aw_mask = int'($urandom_range(0, 63));
      end
      tick(v, voice, op);
    end
    idle(LAT + 2);

    // Algorithm write on the cycle its ID enters: old word now, new word next.
    aw_en = 1; aw_voice = 0; aw_op = 0; aw_mask = 6'b000001;
    tick(0, 0, 0);
    aw_en = 1; aw_voice = 0; aw_op = 0; aw_mask = 6'b000011;
    tick(1, 0, 0);
    tick(1, 0, 0);
    idle(LAT - 1);
    check("rw_old_valid", o_Valid, 1);
    check("rw_old_phase", o_ModulationPhase, 256);
    check("rw_old_alg", o_AlgorithmWord.ModulateWithOP, 1);
    idle(1);
    check("rw_new_phase", o_ModulationPhase, 512);
    check("rw_new_alg", o_AlgorithmWord.ModulateWithOP, 3);
    idle(2);

    // Reset with five items in flight.
    for (int n = 0; n < 5; n++) tick(1, n + 3, n % 6);
    i_Reset_n = 1'b0;
    #1;
    check("mid_rst_valid", o_Valid, 0);
    check("mid_rst_phase", o_ModulationPhase, 0);
    check("mid_rst_id", {o_VoiceOperator.voice, o_VoiceOperator.op}, 0);
    check("mid_rst_alg", o_AlgorithmWord.ModulateWithOP, 0);
    @(posedge i_Clock);
    @(negedge i_Clock);
    i_Reset_n = 1'b1;
    sb_reset();
    idle(12);
    tick(1, 7, 2);
    idle(LAT);
    check("post_rst_valid", o_Valid, 1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_modulation_param.md
STAGE_MODULATION_PARAM -- requirements
Module: stage_modulation_param

Interface
REQ-001 Parameter NUM_VOICES, default 32: voices per pipeline pass.
REQ-002 Parameter NUM_OPS, default 6: operators per voice; also the modulation mask width.
REQ-003 Parameter SAMPLE_W, default 16: operator-sample and output width.
REQ-004 Parameter OUT_SHIFT, default 3: arithmetic right shift applied to the accumulated sum.
REQ-005 i_Clock  in  1  sole clock; all logic rises on its posedge.
REQ-006 i_Reset_n  in  1  reset, asynchronous and active-low.
REQ-007 i_Valid  in  1  i_VoiceOperator is valid this cycle.
REQ-008 i_VoiceOperator  in  VoiceOperatorID_t  {voice, op} being evaluated.
REQ-009 o_Valid  out  1  outputs carry a result.
REQ-010 o_VoiceOperator  out  VoiceOperatorID_t  ID of the result.
REQ-011 o_ModulationPhase  out  SAMPLE_W signed  scaled modulation sum.
REQ-012 o_AlgorithmWord  out  AlgorithmWord_t  algorithm word used for the result.
REQ-013 i_AlgorithmWriteEnable / i_AlgorithmWriteAddr / i_AlgorithmWriteData  in  1 / VoiceOperatorID_t / AlgorithmWord_t  algorithm-table write port.
REQ-014 i_OperatorWriteEnable / i_OperatorWriteAddr / i_OperatorWriteData  in  1 / VoiceOperatorID_t / SAMPLE_W signed  operator-output memory write port (from output stage).

Function
REQ-015 Fully pipelined, no backpressure: one accepted ID per cycle, every i_Valid cycle.
REQ-016 Latency exactly NUM_OPS+2 cycles: i_Valid at edge N produces o_Valid at edge N+NUM_OPS+2.
REQ-017 Stage 0 captures the ID, its algorithm word and its valid bit.
REQ-018 Stage k (1..NUM_OPS): add the stored output of operator k-1 of the same voice if ModulateWithOP[k-1]=1, else add 0.
REQ-019 Accumulator width ACC_W = SAMPLE_W + clog2(NUM_OPS); inputs sign-extended; no internal overflow possible.
REQ-020 Final stage: o_ModulationPhase = (acc >>> OUT_SHIFT), narrowed to SAMPLE_W per REQ-030/031.
REQ-021 Algorithm word captured at stage 0 is carried with the ID; later table writes do not affect in-flight items.
REQ-022 Memories are read-first: a write and a read of the same address in the same cycle return the old value.
REQ-023 Each accumulate stage owns its own operator-memory replica; all replicas are written together.
REQ-024 Bubbles (i_Valid=0) propagate as o_Valid=0; data outputs hold their last value while o_Valid=0.
REQ-025 Simultaneous algorithm and operator writes to any addresses are both performed.

Reset
REQ-026 While i_Reset_n=0: every valid bit, o_Valid, o_ModulationPhase, o_VoiceOperator and o_AlgorithmWord clear to 0 immediately.
REQ-027 Reset mid-stream discards all in-flight items; none emerge after release.
REQ-028 Algorithm table and operator memories are not reset; software programs them before issuing i_Valid.
REQ-029 First accepted i_Valid occurs at the first posedge after i_Reset_n deasserts.

Configuration
REQ-030 With STAGE_MODULATION_SATURATE_EN defined: shifted sum clamps to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
REQ-031 Without STAGE_MODULATION_SATURATE_EN: take bits [SAMPLE_W-1:0] of the shifted sum (two's-complement wrap).

Structure
REQ-032 Shared package synth.svh holds NUM_VOICES, NUM_OPS, VoiceOperatorID_t and AlgorithmWord_t (ModulateWithOP[NUM_OPS-1:0]).
REQ-033 One sub-module, modulation_tap: one accumulate stage comprising its memory replica, conditional add and pipeline registers; instantiated NUM_OPS times.

Verification (NUM_OPS=6, SAMPLE_W=16, unless stated)
REQ-034 Single tap, OUT_SHIFT=3: all op outputs of voice 0 = 16'sh0800, mask 6'b000001, i_Valid at edge 0 -> o_Valid and o_ModulationPhase=16'sh0100 at edge 8 only.
REQ-035 Negative full mask, OUT_SHIFT=3: all outputs -32768, mask 6'b111111 -> o_ModulationPhase=-24576.
REQ-036 Overflow, OUT_SHIFT=0: all outputs 32767, mask 6'b111111 -> 32767 with STAGE_MODULATION_SATURATE_EN, -6 without.
REQ-037 Stream voices 0..31 with random i_Valid gaps and masks -> o_Valid is i_Valid delayed 8 cycles; every o_ModulationPhase and o_VoiceOperator matches the model.
REQ-038 Algorithm write to ID X on the cycle ID X enters -> result uses the old word; next entry of X uses the new word.
REQ-039 i_Reset_n low for 1 cycle with 5 items in flight -> outputs 0 at once; o_Valid stays 0 until a new i_Valid plus 8 cycles.
